// File: rtl/fifo_pkg.sv
// Shared width helpers for the skewed multi-lane FIFO array.
package fifo_pkg;

  function automatic int lane_w(input int data_width);
    return 2 * data_width;
  endfunction

  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_lane_mem.sv
// Storage for one FIFO lane: one write port, one registered read port that
// returns zero whenever no read is issued or the output is being cleared.
module fifo_lane_mem #(
  parameter int WORD_W = 16,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     clr_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [WORD_W-1:0]        wdata_i,
  input  logic                     re_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [WORD_W-1:0]        rdata_o
);

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [WORD_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk) begin
    if (clr_i || !re_i) rdata_q <= '0;
    else                rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/fifo_array_skew.sv
// Array of lockstep-written FIFO lanes with a shared write pointer and
// per-lane read pointers; reads are optionally staggered one cycle per lane.
module fifo_array_skew
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int NUM_MODULES = 16,
  parameter int FIFO_DEPTH  = 16,
  parameter int SKEW_EN     = 1
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        wr_clr,
  input  logic                                        rd_clr,
  input  logic                                        wr_en,
  input  logic                                        rd_en,
  input  logic [NUM_MODULES*lane_w(DATA_WIDTH)-1:0]   data_in,
  output logic [NUM_MODULES*lane_w(DATA_WIDTH)-1:0]   data_out,
  output logic [NUM_MODULES-1:0]                      valid_out,
  output logic                                        full,
  output logic                                        empty,
  output logic [$clog2(FIFO_DEPTH):0]                 count,
  output logic                                        overflow,
  output logic                                        underflow
);

  localparam int LW = lane_w(DATA_WIDTH);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = ptr_w(FIFO_DEPTH);

  logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]          rd_ptr_q [NUM_MODULES];
  logic [PW-1:0]          rd_ptr_d [NUM_MODULES];
  logic [NUM_MODULES-1:0] rd_req, pop, valid_q, valid_d;
  logic                   ovf_q, ovf_d, unf_q, unf_d;
  logic                   rd_en_eff, push;

  assign rd_en_eff = rd_en & ~rd_clr;

  // Lane i sees the pop request i cycles after lane 0 when skewing.
  if (SKEW_EN != 0 && NUM_MODULES > 1) begin : g_skew
    logic [NUM_MODULES-2:0] dl_q, dl_d;

    always_comb begin
      dl_d = '0;
      if (!rd_clr) begin
        dl_d[0] = rd_en;
        for (int i = 1; i < NUM_MODULES - 1; i++) dl_d[i] = dl_q[i-1];
      end
    end

    always_ff @(posedge clk) begin
      if (rst) dl_q <= '0;
      else     dl_q <= dl_d;
    end

    assign rd_req = {dl_q, rd_en_eff} & {NUM_MODULES{~rd_clr}};
  end else begin : g_lock
    assign rd_req = {NUM_MODULES{rd_en_eff}};
  end

  assign count = wr_ptr_q - rd_ptr_q[NUM_MODULES-1];
  assign full  = (count == PW'(FIFO_DEPTH));
  assign empty = (wr_ptr_q == rd_ptr_q[0]);
  assign push  = wr_en & ~wr_clr & ~full & ~rst;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    pop      = '0;
    valid_d  = '0;
    ovf_d    = ovf_q;
    unf_d    = unf_q;

    if (wr_clr)    wr_ptr_d = '0;
    else if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (wr_en && !wr_clr && full) ovf_d = 1'b1;

    for (int i = 0; i < NUM_MODULES; i++) begin
      pop[i]     = rd_req[i] && (wr_ptr_q != rd_ptr_q[i]);
      valid_d[i] = pop[i];
      if (rd_req[i] && !pop[i]) unf_d = 1'b1;
      if (rd_clr)      rd_ptr_d[i] = '0;
      else if (pop[i]) rd_ptr_d[i] = rd_ptr_q[i] + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      for (int i = 0; i < NUM_MODULES; i++) rd_ptr_q[i] <= '0;
      valid_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  for (genvar g = 0; g < NUM_MODULES; g++) begin : g_lane
    fifo_lane_mem #(
      .WORD_W (LW),
      .DEPTH  (FIFO_DEPTH)
    ) u_mem (
      .clk     (clk),
      .clr_i   (rst | rd_clr),
      .we_i    (push),
      .waddr_i (wr_ptr_q[AW-1:0]),
      .wdata_i (data_in[g*LW +: LW]),
      .re_i    (pop[g]),
      .raddr_i (rd_ptr_q[g][AW-1:0]),
      .rdata_o (data_out[g*LW +: LW])
    );
  end

  assign valid_out = valid_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: tb/tb_fifo_array_skew.sv
// Bench for fifo_array_skew: directed scenarios plus random traffic against
// an occupancy-count reference model, for a skewed and a lockstep instance.
module tb_fifo_array_skew;

  localparam int NM  = 4;
  localparam int DEP = 4;
  localparam int DW  = 8;
  localparam int LW  = 2 * DW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, wr_clr = 1'b0, rd_clr = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
  logic [NM*LW-1:0] data_in = '0;

  logic [NM*LW-1:0] dout0, dout1;
  logic [NM-1:0]    vld0, vld1;
  logic             full0, full1, empty0, empty1, ovf0, ovf1, unf0, unf1;
  logic [2:0]       cnt0, cnt1;

  int checks = 0;
  int errors = 0;

  fifo_array_skew #(.DATA_WIDTH(DW), .NUM_MODULES(NM), .FIFO_DEPTH(DEP), .SKEW_EN(1)) u_skew (
    .clk(clk), .rst(rst), .wr_clr(wr_clr), .rd_clr(rd_clr), .wr_en(wr_en), .rd_en(rd_en),
    .data_in(data_in), .data_out(dout1), .valid_out(vld1), .full(full1), .empty(empty1),
    .count(cnt1), .overflow(ovf1), .underflow(unf1));

  fifo_array_skew #(.DATA_WIDTH(DW), .NUM_MODULES(NM), .FIFO_DEPTH(DEP), .SKEW_EN(0)) u_lock (
    .clk(clk), .rst(rst), .wr_clr(wr_clr), .rd_clr(rd_clr), .wr_en(wr_en), .rd_en(rd_en),
    .data_in(data_in), .data_out(dout0), .valid_out(vld0), .full(full0), .empty(empty0),
    .count(cnt0), .overflow(ovf0), .underflow(unf0));

  // Reference model, index 0 = lockstep, 1 = skewed; counts are unbounded
  // totals, occupancy is taken modulo twice the depth like the pointers.
  int           wcnt [2];
  int           rcnt [2][NM];
  logic [LW-1:0] store [2][NM][DEP];
  bit           hist [NM];
  logic [NM*LW-1:0] m_dout [2];
  logic [NM-1:0]    m_vld [2];
  bit           m_ovf [2], m_unf [2];

  function automatic int occ(input int s, input int lane);
    return (((wcnt[s] - rcnt[s][lane]) % (2*DEP)) + 2*DEP) % (2*DEP);
  endfunction

  task automatic model_edge();
    bit req, full_pre;
    logic [NM*LW-1:0] nd;
    logic [NM-1:0] nv;
    for (int s = 0; s < 2; s++) begin
      if (rst) begin
        wcnt[s] = 0;
        for (int i = 0; i < NM; i++) rcnt[s][i] = 0;
        m_dout[s] = '0; m_vld[s] = '0; m_ovf[s] = 0; m_unf[s] = 0;
      end else begin
        full_pre = (occ(s, NM-1) == DEP);
        nd = '0; nv = '0;
        for (int i = 0; i < NM; i++) begin
          req = !rd_clr && ((s == 0 || i == 0) ? rd_en : hist[i-1]);
          if (req) begin
            if (occ(s, i) != 0) begin
              nd[i*LW +: LW] = store[s][i][rcnt[s][i] % DEP];
              nv[i] = 1'b1;
              rcnt[s][i]++;
            end else m_unf[s] = 1;
          end
        end
        if (rd_clr) for (int i = 0; i < NM; i++) rcnt[s][i] = 0;
        if (wr_clr) wcnt[s] = 0;
        else if (wr_en) begin
          if (full_pre) m_ovf[s] = 1;
          else begin
            for (int i = 0; i < NM; i++) store[s][i][wcnt[s] % DEP] = data_in[i*LW +: LW];
            wcnt[s]++;
          end
        end
        m_dout[s] = nd; m_vld[s] = nv;
      end
    end
    if (rst || rd_clr) for (int k = 0; k < NM; k++) hist[k] = 0;
    else begin
      for (int k = NM-1; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = rd_en;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; wr_en = 0; rd_en = 0; wr_clr = 0; rd_clr = 0;
    step();
    rst = 1'b0;
  endtask

  task automatic write_word(input int k);
    wr_en = 1'b1;
    for (int i = 0; i < NM; i++) data_in[i*LW +: LW] = LW'(16*k + i);
    step();
    wr_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    checks++; if (cnt1 !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", cnt1); end
    checks++; if (empty1 !== 1'b1) begin errors++; $display("FAIL reset_empty got %b want 1", empty1); end
    checks++; if (full1 !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", full1); end
    checks++; if (vld1 !== 4'b0000) begin errors++; $display("FAIL reset_valid got %b want 0000", vld1); end
    checks++; if (dout1 !== '0) begin errors++; $display("FAIL reset_data got %h want 0", dout1); end
    checks++; if ({ovf1, unf1} !== 2'b00) begin errors++; $display("FAIL reset_sticky got %b want 00", {ovf1, unf1}); end
    rst = 1'b0;
  endtask

  task automatic test_skew_read();
    logic [NM*LW-1:0] e;
    do_reset();
    for (int k = 0; k < 4; k++) write_word(k);
    rd_en = 1'b1; step(); rd_en = 1'b0;
    checks++; if (vld0 !== 4'b1111) begin errors++; $display("FAIL lockstep_wave_valid got %b want 1111", vld0); end
    for (int c = 0; c < NM; c++) begin
      if (c > 0) step();
      e = '0; e[c*LW +: LW] = LW'(c);
      checks++; if (vld1 !== 4'(1 << c)) begin errors++; $display("FAIL skew_valid c%0d got %b want %b", c, vld1, 4'(1 << c)); end
      checks++; if (dout1 !== e) begin errors++; $display("FAIL skew_data c%0d got %h want %h", c, dout1, e); end
    end
  endtask

  task automatic test_overflow();
    int n3 = 0;
    do_reset();
    for (int k = 0; k < 4; k++) write_word(k);
    checks++; if ({full1, cnt1, ovf1} !== {1'b1, 3'd4, 1'b0}) begin errors++; $display("FAIL fill4 got full=%b cnt=%0d ovf=%b want 1 4 0", full1, cnt1, ovf1); end
    write_word(4);
    checks++; if ({full1, cnt1, ovf1} !== {1'b1, 3'd4, 1'b1}) begin errors++; $display("FAIL push5 got full=%b cnt=%0d ovf=%b want 1 4 1", full1, cnt1, ovf1); end
    for (int c = 0; c < 7; c++) begin
      rd_en = (c < 4);
      step();
      if (c < 4) begin
        checks++; if (dout1[0 +: LW] !== LW'(16*c)) begin errors++; $display("FAIL drain_lane0 c%0d got %h want %h", c, dout1[0 +: LW], LW'(16*c)); end
      end
      if (vld1[3]) begin
        checks++; if (dout1[3*LW +: LW] !== LW'(16*n3 + 3)) begin errors++; $display("FAIL drain_lane3 n%0d got %h want %h", n3, dout1[3*LW +: LW], LW'(16*n3 + 3)); end
        n3++;
      end
    end
    rd_en = 1'b0;
    checks++; if (n3 !== 4) begin errors++; $display("FAIL drain_lane3_pops got %0d want 4", n3); end
    checks++; if ({cnt1, empty1} !== {3'd0, 1'b1}) begin errors++; $display("FAIL drained got cnt=%0d empty=%b want 0 1", cnt1, empty1); end
  endtask

  task automatic test_underflow();
    do_reset();
    rd_en = 1'b1; step(); rd_en = 1'b0;
    checks++; if ({unf1, vld1} !== {1'b1, 4'b0000}) begin errors++; $display("FAIL underflow got unf=%b vld=%b want 1 0000", unf1, vld1); end
    checks++; if (dout1 !== '0) begin errors++; $display("FAIL underflow_data got %h want 0", dout1); end
    for (int c = 0; c < 4; c++) begin
      step();
      checks++; if ({vld1, cnt1, empty1} !== {4'b0000, 3'd0, 1'b1}) begin errors++; $display("FAIL underflow_idle c%0d got vld=%b cnt=%0d empty=%b", c, vld1, cnt1, empty1); end
    end
    write_word(5);
    rd_en = 1'b1; step(); rd_en = 1'b0;
    checks++; if ({vld1[0], dout1[0 +: LW]} !== {1'b1, 16'd80}) begin errors++; $display("FAIL after_underflow got vld=%b data=%h want 1 0050", vld1[0], dout1[0 +: LW]); end
  endtask

  task automatic test_full_rw();
    do_reset();
    for (int k = 0; k < 4; k++) write_word(k);
    wr_en = 1'b1; rd_en = 1'b1;
    for (int i = 0; i < NM; i++) data_in[i*LW +: LW] = LW'(16*9 + i);
    step();
    wr_en = 1'b0; rd_en = 1'b0;
    checks++; if ({vld1, dout1[0 +: LW], ovf1, cnt1} !== {4'b0001, 16'd0, 1'b1, 3'd4}) begin errors++; $display("FAIL full_rw got vld=%b d0=%h ovf=%b cnt=%0d want 0001 0000 1 4", vld1, dout1[0 +: LW], ovf1, cnt1); end
    for (int c = 1; c < 4; c++) begin
      step();
      checks++; if (cnt1 !== ((c == 3) ? 3'd3 : 3'd4)) begin errors++; $display("FAIL full_rw_count c%0d got %0d want %0d", c, cnt1, (c == 3) ? 3 : 4); end
    end
    checks++; if ({vld1, dout1[3*LW +: LW]} !== {4'b1000, 16'd3}) begin errors++; $display("FAIL full_rw_lane3 got vld=%b d3=%h want 1000 0003", vld1, dout1[3*LW +: LW]); end
  endtask

  task automatic test_lockstep();
    do_reset();
    write_word(0); write_word(1);
    rd_en = 1'b1; step();
    checks++; if ({vld0, dout0} !== {4'b1111, 64'h0003_0002_0001_0000}) begin errors++; $display("FAIL lock_pop0 got vld=%b data=%h", vld0, dout0); end
    step(); rd_en = 1'b0;
    checks++; if ({vld0, dout0} !== {4'b1111, 64'h0013_0012_0011_0010}) begin errors++; $display("FAIL lock_pop1 got vld=%b data=%h", vld0, dout0); end
    checks++; if ({empty0, cnt0, unf0} !== {1'b1, 3'd0, 1'b0}) begin errors++; $display("FAIL lock_empty got empty=%b cnt=%0d unf=%b want 1 0 0", empty0, cnt0, unf0); end
  endtask

  task automatic test_rst_midwave();
    do_reset();
    for (int k = 0; k < 4; k++) write_word(k);
    rd_en = 1'b1; step(); rd_en = 1'b0; step();
    rst = 1'b1; step(); rst = 1'b0;
    checks++; if ({vld1, cnt1, empty1} !== {4'b0000, 3'd0, 1'b1}) begin errors++; $display("FAIL midwave_rst got vld=%b cnt=%0d empty=%b want 0000 0 1", vld1, cnt1, empty1); end
    for (int c = 0; c < 4; c++) begin
      step();
      checks++; if ({vld1, unf1} !== {4'b0000, 1'b0}) begin errors++; $display("FAIL midwave_late c%0d got vld=%b unf=%b want 0000 0", c, vld1, unf1); end
    end
  endtask

  task automatic test_random();
    logic [NM*LW+9:0] got, exp;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      wr_en  = ($urandom_range(0, 9) < 5);
      rd_en  = ($urandom_range(0, 9) < 4);
      wr_clr = ($urandom_range(0, 49) == 0);
      rd_clr = ($urandom_range(0, 49) == 0);
      rst    = ($urandom_range(0, 99) == 0);
      data_in = {$urandom, $urandom};
      step();
      for (int s = 0; s < 2; s++) begin
        got = (s == 1) ? {dout1, vld1, cnt1, full1, empty1, ovf1, unf1}
                       : {dout0, vld0, cnt0, full0, empty0, ovf0, unf0};
        exp = {m_dout[s], m_vld[s], 3'(occ(s, NM-1)), occ(s, NM-1) == DEP, occ(s, 0) == 0,
               m_ovf[s], m_unf[s]};
        checks++; if (got !== exp) begin errors++; $display("FAIL random s%0d n%0d got %h want %h", s, n, got, exp); end
      end
    end
    wr_en = 0; rd_en = 0; wr_clr = 0; rd_clr = 0; rst = 0;
  endtask

  initial begin
    test_reset();
    test_skew_read();
    test_overflow();
    test_underflow();
    test_full_rw();
    test_lockstep();
    test_rst_midwave();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_array_skew.md
FIFO_ARRAY_SKEW -- requirements
Module: fifo_array_skew

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, operand width; each lane word is DATA_WIDTH*2 bits.
REQ-002 SHALL have parameter NUM_MODULES, default 16, lane count, at least 1.
REQ-003 SHALL have parameter FIFO_DEPTH, default 16, words per lane, a power of 2 and at least 2; ADDR_WIDTH = clog2(FIFO_DEPTH).
REQ-004 SHALL have parameter SKEW_EN, default 1: 1 = diagonal (staggered) read, 0 = all lanes read in lockstep.
REQ-005 SHALL have port clk, input, 1 bit, the single clock; all logic is on the rising edge.
REQ-006 SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-007 SHALL have port wr_clr, input, 1 bit, synchronous clear of the write pointer.
REQ-008 SHALL have port rd_clr, input, 1 bit, synchronous clear of all read pointers and the skew pipeline.
REQ-009 SHALL have port wr_en, input, 1 bit, push one word into every lane.
REQ-010 SHALL have port rd_en, input, 1 bit, start a pop wave.
REQ-011 SHALL have port data_in, input, NUM_MODULES*DATA_WIDTH*2 bits; lane i is slice [i*DATA_WIDTH*2 +: DATA_WIDTH*2].
REQ-012 SHALL have port data_out, output, NUM_MODULES*DATA_WIDTH*2 bits, registered, with the same lane slicing as data_in.
REQ-013 SHALL have port valid_out, output, NUM_MODULES bits, per-lane valid flag for data_out.
REQ-014 SHALL have port full, output, 1 bit; port empty, output, 1 bit; port count, output, ADDR_WIDTH+1 bits.
REQ-015 SHALL have port overflow, output, 1 bit, sticky; port underflow, output, 1 bit, sticky.

Function
REQ-016 SHALL keep one shared write pointer wr_ptr and one read pointer rd_ptr[i] per lane, each ADDR_WIDTH+1 bits, wrapping modulo 2*FIFO_DEPTH.
REQ-017 SHALL, on wr_en with full low, write data_in lane i to lane i storage at wr_ptr and increment wr_ptr.
REQ-018 SHALL drop a write attempted while full, with no pointer or storage change, and set overflow.
REQ-019 SHALL derive a per-lane pop request rd_req[i]:
- SKEW_EN=1: rd_req[i] = rd_en delayed i cycles, so rd_req[0] = rd_en.
- SKEW_EN=0: rd_req[i] = rd_en for every lane.
REQ-020 SHALL, on rd_req[i] with lane i non-empty (wr_ptr != rd_ptr[i]), increment rd_ptr[i], register the word into the lane-i slice of data_out and set valid_out[i] on the next cycle (latency 1).
REQ-021 SHALL, on rd_req[i] with lane i empty, leave rd_ptr[i] unchanged, drive lane i of data_out to zero, clear valid_out[i] and set underflow.
REQ-022 SHALL drive lane i of data_out to zero with valid_out[i] low in any cycle after one with no pop on lane i.
REQ-023 SHALL compute:
- count = wr_ptr - rd_ptr[NUM_MODULES-1], the slowest lane;
- full = (count == FIFO_DEPTH);
- empty = (wr_ptr == rd_ptr[0]).
All three are combinational from registers.
REQ-024 SHALL use pre-edge pointers for simultaneous wr_en and rd_req on one lane:
- when full, the pop proceeds and the push is still dropped (no write-through);
- when empty, the push is accepted, the pop underflows and there is no bypass.
REQ-025 SHALL, on wr_clr, set wr_ptr to 0 and leave storage unchanged; a wr_en in the same cycle is ignored.
REQ-026 SHALL, on rd_clr:
- set all rd_ptr to 0;
- flush the skew delay line to 0;
- clear valid_out;
- ignore an rd_en in the same cycle.
REQ-027 SHALL treat the two clears as independent; both together equal an empty FIFO, with overflow and underflow kept.
REQ-028 SHALL clear overflow and underflow only on rst.

Reset
REQ-029 SHALL, on rst, zero wr_ptr, all rd_ptr, the skew delay line, data_out, valid_out, overflow and underflow; storage is not reset.
REQ-030 SHALL give rst priority over wr_clr, rd_clr, wr_en and rd_en; rst asserted mid-wave aborts every pending lane pop.
REQ-031 SHALL present empty=1, full=0 and count=0 in the cycle after rst.

Structure
REQ-032 SHALL place the lane word-width expression and the pointer-width function in the shared package fifo_pkg.
REQ-033 SHALL use one sub-module, fifo_lane_mem: a single lane's storage with one write port and one registered read port, instantiated NUM_MODULES times.
REQ-034 SHALL keep pointers, skew delay line, flags and error bits in fifo_array_skew.

Verification
REQ-035 SHALL cover, with NUM_MODULES=4, FIFO_DEPTH=4, SKEW_EN=1: write 4 words (lane i word k = 16*k+i); pulse rd_en once -> valid_out = 0001, 0010, 0100, 1000 on cycles +1 to +4, lane i data = i.
REQ-036 SHALL cover: write 4 words, then a 5th -> full=1, count=4, overflow=1, 5th word never read.
REQ-037 SHALL cover: rd_en on an empty FIFO -> underflow=1, data_out = 0, valid_out = 0000, pointers unchanged.
REQ-038 SHALL cover: full FIFO with wr_en and rd_en held 1 cycle -> lane 0 pops word 0, push dropped, overflow=1; count stays 4 until lane 3 pops.
REQ-039 SHALL cover: SKEW_EN=0, 2 words written, rd_en 2 cycles -> valid_out = 1111 on both following cycles, empty=1 after.
REQ-040 SHALL cover: rst asserted 2 cycles into a skew wave -> valid_out = 0000, count=0 and empty=1 next cycle; no late lane pops.
